// File: rtl/sdram_slot_mux.sv
// Front end for the 8-bit SDRAM controller: merges a priority CPU port and a
// FIFO-buffered loader stream into one access per clkref slot.
module sdram_slot_mux #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkref,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dout,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              mem_oe,
    output logic              mem_we
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CPU_RD, CPU_WR, LD_WR} grant_t;

    grant_t            state, state_nx;
    logic              ref_d;
    logic              fall;
    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W+7:0] head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty, push, pop;
    logic              oe_nx, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        din_nx;

    // Grants change only on falling edges so mem_* settles half a slot
    // before the controller samples on the rising edge.
    assign fall       = ref_d & ~clkref;
    assign fifo_empty = (count == '0);
    assign ld_ready   = ~reset & (count != FULL);
    assign push       = ld_valid & ld_ready;
    assign head       = fifo_mem[rd_ptr];
    assign ld_busy    = ~fifo_empty | (state == LD_WR);

    always_comb begin
        state_nx = state;
        oe_nx    = mem_oe;
        we_nx    = mem_we;
        addr_nx  = mem_addr;
        din_nx   = mem_din;
        pop      = 1'b0;
        if (fall) begin
            if (cpu_we) begin
                state_nx = CPU_WR;
                oe_nx    = 1'b0;
                we_nx    = 1'b1;
                addr_nx  = cpu_addr;
                din_nx   = cpu_din;
            end else if (cpu_oe) begin
                state_nx = CPU_RD;
                oe_nx    = 1'b1;
                we_nx    = 1'b0;
                addr_nx  = cpu_addr;
            end else if (!fifo_empty) begin
                state_nx = LD_WR;
                oe_nx    = 1'b0;
                we_nx    = 1'b1;
                addr_nx  = head[ADDR_W+7:8];
                din_nx   = head[7:0];
                pop      = 1'b1;
            end else begin
                state_nx = IDLE;
                oe_nx    = 1'b0;
                we_nx    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ref_d    <= 1'b0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            cpu_dout <= 8'hFF;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            ref_d    <= clkref;
            state    <= state_nx;
            mem_oe   <= oe_nx;
            mem_we   <= we_nx;
            mem_addr <= addr_nx;
            mem_din  <= din_nx;
            // The slot that just ended was the read; its data is on mem_dout now.
            if (fall && state == CPU_RD)
                cpu_dout <= mem_dout;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {ld_addr, ld_data};
    end
endmodule

// File: tb/tb_sdram_slot_mux.sv
// Randomized scoreboard bench for sdram_slot_mux: a queue-based slot model
// predicts every cycle's outputs; a monitor compares them one cycle at a time.
module tb_sdram_slot_mux;
    localparam int AW    = 25;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, clkref;
    logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
    logic [7:0]    cpu_din, cpu_dout, ld_data, mem_din, mem_dout;
    logic          cpu_oe, cpu_we, ld_valid, ld_ready, ld_busy, mem_oe, mem_we;

    sdram_slot_mux #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
        .cpu_dout(cpu_dout),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_busy(ld_busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_oe(mem_oe), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // Memory stub: read data is a fixed function of the address being read.
    assign mem_dout = mem_oe ? (mem_addr[7:0] ^ 8'h4A) : 8'h00;

    typedef struct {
        logic          oe, we, ready, busy;
        logic [AW-1:0] addr;
        logic [7:0]    din, dout;
    } exp_t;

    exp_t            exp_q[$];
    logic [AW+7:0]   mq[$];
    int              tests = 0;
    int              fails = 0;

    bit              m_ref, m_rd, m_ld, m_oe, m_we, m_fall, m_acc;
    logic [AW-1:0]   m_addr;
    logic [7:0]      m_din, m_dout;
    bit              ref_run = 0;
    bit              rand_ref = 0;
    int              ref_cnt = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Predict the state after the coming posedge from the inputs now applied.
    task automatic model_step();
        exp_t          e;
        logic [AW+7:0] ent;
        bit            can_push;
        m_fall = 0;
        m_acc  = 0;
        if (reset) begin
            mq.delete();
            m_ref = 0; m_rd = 0; m_ld = 0; m_oe = 0; m_we = 0;
            m_addr = '0; m_din = '0; m_dout = 8'hFF;
        end else begin
            can_push = (mq.size() < DEPTH);
            m_fall   = m_ref && !clkref;
            if (m_fall) begin
                if (m_rd) m_dout = m_addr[7:0] ^ 8'h4A;
                m_rd = 0;
                m_ld = 0;
                if (cpu_we) begin
                    m_we = 1; m_oe = 0; m_addr = cpu_addr; m_din = cpu_din;
                end else if (cpu_oe) begin
                    m_rd = 1; m_oe = 1; m_we = 0; m_addr = cpu_addr;
                end else if (mq.size() != 0) begin
                    ent  = mq.pop_front();
                    m_ld = 1; m_we = 1; m_oe = 0;
                    m_addr = ent[AW+7:8];
                    m_din  = ent[7:0];
                end else begin
                    m_oe = 0; m_we = 0;
                end
            end
            if (ld_valid && can_push) begin
                mq.push_back({ld_addr, ld_data});
                m_acc = 1;
            end
            m_ref = clkref;
        end
        e.oe    = m_oe;
        e.we    = m_we;
        e.addr  = m_addr;
        e.din   = m_din;
        e.dout  = m_dout;
        e.ready = !reset && (mq.size() != DEPTH);
        e.busy  = (mq.size() != 0) || m_ld;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        if (ref_run) begin
            if (ref_cnt == 0) begin
                clkref  = ~clkref;
                ref_cnt = rand_ref ? int'($urandom_range(1, 4)) : 3;
            end else begin
                ref_cnt--;
            end
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d);
        bit ok = 0;
        ld_valid = 1; ld_addr = a; ld_data = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            cyc();
            ok = m_acc;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ld_accept: byte %0h not accepted, required within 200 cycles", a);
        end
        ld_valid = 0;
    endtask

    task automatic wait_fall();
        bit seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            cyc();
            seen = m_fall;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL slot_timeout: no falling edge seen, required within 100 cycles");
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
            end else begin
                e = exp_q.pop_front();
                chk("mem_oe",   32'(mem_oe),   32'(e.oe));
                chk("mem_we",   32'(mem_we),   32'(e.we));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_din",  32'(mem_din),  32'(e.din));
                chk("cpu_dout", 32'(cpu_dout), 32'(e.dout));
                chk("ld_ready", 32'(ld_ready), 32'(e.ready));
                chk("ld_busy",  32'(ld_busy),  32'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    initial begin : driver
        bit got;
        reset = 1; clkref = 0; cpu_addr = '0; cpu_din = '0; cpu_oe = 0; cpu_we = 0;
        ld_valid = 0; ld_addr = '0; ld_data = '0;
        repeat (3) cyc();
        reset = 0;

        // Idle slots
        ref_run = 1;
        repeat (24) cyc();

        // Three loader bytes stream out in consecutive slots
        for (int i = 0; i < 3; i++)
            push_byte(AW'(32'h100 + i), 8'(8'hA0 + i));
        repeat (40) cyc();

        // CPU write preempts two queued loader entries
        ref_run = 0;
        push_byte(AW'(32'h300), 8'h31);
        push_byte(AW'(32'h301), 8'h32);
        cpu_we = 1; cpu_addr = AW'(32'h2000); cpu_din = 8'h55;
        ref_run = 1;
        wait_fall();
        cpu_we = 0;
        repeat (32) cyc();

        // CPU read of 0x1234 returns 0x7E one slot later, then holds
        cpu_oe = 1; cpu_addr = AW'(32'h1234);
        wait_fall();
        cpu_oe = 0;
        repeat (32) cyc();

        // Fill FIFO with clkref stopped; 17th byte waits for the first pop
        ref_run = 0;
        for (int i = 0; i < DEPTH; i++)
            push_byte(AW'(32'h400 + i), 8'(8'h10 + i));
        ld_valid = 1; ld_addr = AW'(32'h4FF); ld_data = 8'hEE;
        repeat (5) cyc();
        ref_run = 1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            cyc();
            got = m_acc;
        end
        ld_valid = 0;
        repeat (DEPTH * 8 + 24) cyc();

        // Reset during a loader slot with five entries still queued
        ref_run = 0;
        for (int i = 0; i < 6; i++)
            push_byte(AW'(32'h500 + i), 8'(8'hC0 + i));
        ref_run = 1;
        for (int k = 0; k < 100 && !m_ld; k++) cyc();
        repeat (2) cyc();
        reset = 1;
        repeat (2) cyc();
        reset = 0;
        repeat (32) cyc();

        // Randomized traffic with irregular slot lengths and rare resets
        rand_ref = 1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                cpu_we   = ($urandom_range(0, 5) == 0);
                cpu_oe   = ($urandom_range(0, 3) == 0);
                cpu_addr = AW'($urandom);
                cpu_din  = 8'($urandom);
            end
            if (!ld_valid || m_acc) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr  = AW'($urandom);
                ld_data  = 8'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0);
            cyc();
        end
        reset = 0; cpu_we = 0; cpu_oe = 0; ld_valid = 0;
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
